serial_debug_node: RTL

- Store-and-forward node on the serial debug ring.
- Shifts in a 144-bit frame from the upstream hop. If the frame address matches this node, it performs a local register write or read. It then retransmits the frame to the downstream hop.
- Nodes are chained between the UART bridge's debug output and input. Each node exposes one 128-bit write register and one 128-bit read port to local logic.

---
 rtl/serial_debug_node.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/serial_debug_node.sv
// serial_debug_node: store-and-forward node on the serial debug ring.
// Shifts in a 144-bit frame {dir, addr[14:0], data[127:0]} MSB first and
// performs a local write/read on an address hit. It then retransmits the
// frame downstream using a prescaled debug clock.
// Optional feature: define SERIAL_DEBUG_NODE_TIMEOUT_EN to discard partial
// frames after TIMEOUT_CYCLES idle clocks.
module serial_debug_node #(
    parameter logic [14:0] NODE_ADDR      = 15'h0001,
    parameter int          TIMEOUT_CYCLES = 65535
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [7:0]   prescaler,
    input  logic         debug_rx_data,
    input  logic         debug_rx_clk,
    output logic         debug_tx_data,
    output logic         debug_tx_clk,
    input  logic [127:0] dbg_in,
    output logic [127:0] dbg_out,
    output logic         dbg_write,
    output logic         dbg_overrun
);

    typedef enum logic [1:0] {S_RX, S_PROC, S_TX} state_t;

    state_t         r_state;
    logic [2:0]     r_clk_sync;
    logic [2:0]     r_dat_sync;
    logic [143:0]   r_buf;
    logic [7:0]     r_cnt;
    logic [7:0]     r_hp;
    logic           r_tx_clk;
    logic           r_tx_data;
    logic [127:0]   r_dbg_out;
    logic           r_dbg_write;
    logic           r_overrun;

    logic           w_rise;
    logic           w_bit;
    logic [7:0]     w_presc;
    logic           w_addr_hit;

    // Stage 2 high while stage 3 still low marks a synced upstream rising edge.
    assign w_rise     = r_clk_sync[1] & ~r_clk_sync[2];
    assign w_bit      = r_dat_sync[1];
    assign w_presc    = (prescaler == 8'd0) ? 8'd1 : prescaler;
    assign w_addr_hit = (r_buf[142:128] == NODE_ADDR);

`ifdef SERIAL_DEBUG_NODE_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] r_to;
`else
    logic w_unused_timeout;
    assign w_unused_timeout = (TIMEOUT_CYCLES == 0);
`endif

    // Synchronise the asynchronous upstream pins; clock pipe resets high so
    // no phantom edge appears when reset releases.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_clk_sync <= 3'b111;
            r_dat_sync <= 3'b000;
        end else begin
            r_clk_sync <= {r_clk_sync[1:0], debug_rx_clk};
            r_dat_sync <= {r_dat_sync[1:0], debug_rx_data};
        end
    end

    // Frame FSM: receive, process locally for one cycle, then retransmit.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= S_RX;
            r_buf       <= '0;
            r_cnt       <= 8'd0;
            r_hp        <= 8'd1;
            r_tx_clk    <= 1'b1;
            r_tx_data   <= 1'b0;
            r_dbg_out   <= '0;
            r_dbg_write <= 1'b0;
            r_overrun   <= 1'b0;
`ifdef SERIAL_DEBUG_NODE_TIMEOUT_EN
            r_to        <= '0;
`endif
        end else begin
            r_dbg_write <= 1'b0;
            case (r_state)
                S_RX: begin
                    if (w_rise) begin
                        r_buf <= {r_buf[142:0], w_bit};
                        r_cnt <= r_cnt + 8'd1;
                        if (r_cnt == 8'd143)
                            r_state <= S_PROC;
`ifdef SERIAL_DEBUG_NODE_TIMEOUT_EN
                        r_to <= '0;
                    end else if (r_cnt != 8'd0) begin
                        // Stalled partial frame: drop it once the idle limit is hit.
                        if (r_to == TW'(TIMEOUT_CYCLES - 1)) begin
                            r_cnt <= 8'd0;
                            r_buf <= '0;
                            r_to  <= '0;
                        end else begin
                            r_to <= r_to + 1'b1;
                        end
                    end else begin
                        r_to <= '0;
`endif
                    end
                end
                S_PROC: begin
                    if (w_addr_hit && r_buf[143]) begin
                        r_dbg_out   <= r_buf[127:0];
                        r_dbg_write <= 1'b1;
                    end else if (w_addr_hit && !r_buf[143]) begin
                        r_buf[127:0] <= dbg_in;
                    end
                    r_hp    <= w_presc;
                    r_cnt   <= 8'd144;
                    r_state <= S_TX;
                end
                S_TX: begin
                    if (r_hp <= 8'd1) begin
                        r_hp <= w_presc;
                        if (!r_tx_clk) begin
                            r_tx_clk <= 1'b1;
                        end else if (r_cnt != 8'd0) begin
                            r_tx_data <= r_buf[143];
                            r_buf     <= {r_buf[142:0], 1'b0};
                            r_cnt     <= r_cnt - 8'd1;
                            r_tx_clk  <= 1'b0;
                        end else begin
                            r_cnt   <= 8'd0;
                            r_state <= S_RX;
                        end
                    end else begin
                        r_hp <= r_hp - 8'd1;
                    end
                end
                default: r_state <= S_RX;
            endcase
            // Upstream edges outside RX cannot be accepted; flag them.
            if (w_rise && r_state != S_RX)
                r_overrun <= 1'b1;
        end
    end

    assign debug_tx_data = r_tx_data;
    assign debug_tx_clk  = r_tx_clk;
    assign dbg_out       = r_dbg_out;
    assign dbg_write     = r_dbg_write;
    assign dbg_overrun   = r_overrun;

endmodule
